seq_shifter_r: RTL and testbench

SEQ_SHIFTER_R -- requirements
Module: seq_shifter_r

---
 rtl/seq_shifter_r.sv | 112 +++++++++++
 tb/tb_seq_shifter_r.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter_r.sv
// Multi-cycle right shifter (logical/arithmetic) with IDLE/SHIFT/DONE control.
// Define SHR_RADIX4_EN to retire two bit positions per SHIFT cycle instead of one.
module seq_shifter_r #(
  parameter int word = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [word-1:0] in,
  input  logic [4:0]      shamt,
  input  logic            arith,
  output logic [word-1:0] out,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [word-1:0] out_r;
  logic [word-1:0] out_s;
  logic [4:0]      cnt_r;
  logic [4:0]      cnt_s;
  logic            fill_r;
  logic            fill_s;
  logic            busy_r;
  logic            done_r;

  // Next-state, datapath and capture logic.
  always_comb begin
    state_s = state_r;
    out_s   = out_r;
    cnt_s   = cnt_r;
    fill_s  = fill_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          out_s  = in;
          cnt_s  = shamt;
          fill_s = arith & in[word-1];
          if (shamt == 5'd0) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
`ifdef SHR_RADIX4_EN
        // Two positions per cycle while at least two remain; an odd count ends with a single step.
        if (cnt_r >= 5'd2) begin
          out_s = {fill_r, fill_r, out_r[word-1:2]};
          cnt_s = cnt_r - 5'd2;
        end else begin
          out_s = {fill_r, out_r[word-1:1]};
          cnt_s = cnt_r - 5'd1;
        end
        if (cnt_r <= 5'd2) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
`else
        out_s = {fill_r, out_r[word-1:1]};
        cnt_s = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
`endif
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and status registers; status flags track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      out_r   <= '0;
      cnt_r   <= 5'd0;
      fill_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      out_r   <= out_s;
      cnt_r   <= cnt_s;
      fill_r  <= fill_s;
      busy_r  <= (state_s == SHIFT);
      done_r  <= (state_s == DONE);
    end
  end

  assign out  = out_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_seq_shifter_r.sv
// Scoreboard bench for seq_shifter_r: stimulus pushes expected result/timing, monitor checks on done.
module tb_seq_shifter_r;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] out;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] res;
    int          dcyc;
    int          bcnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic [31:0] last_exp = 32'h0;

  seq_shifter_r #(.word(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in), .shamt(shamt),
    .arith(arith), .out(out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result from shift operators, done edge from number of bit positions per cycle.
  function automatic int lat(input int n);
`ifdef SHR_RADIX4_EN
    return (n + 1) / 2;
`else
    return n;
`endif
  endfunction

  // Monitor: count busy cycles, compare everything when done is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", out, e.res);
          chk("done_cycle", cyc, e.dcyc);
          chk("busy_cycles", busy_cnt, e.bcnt);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [4:0] s, input logic ar);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    in    = a;
    shamt = s;
    arith = ar;
    e.res  = ar ? 32'($signed(a) >>> s) : (a >> s);
    e.dcyc = cyc + 1 + lat(int'(s));
    e.bcnt = lat(int'(s));
    last_exp = e.res;
    sb.push_back(e);
  endtask

  task automatic wait_done(input bit junk);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (junk) begin
        start = 1'($urandom);
        in    = $urandom;
        shamt = 5'($urandom);
        arith = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=0 expected=1 (t=%0t)", $time);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [4:0] s, input logic ar, input bit junk);
    issue(a, s, ar);
    wait_done(junk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      in    = $urandom;
      chk("idle_hold", out, last_exp);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    in    = 32'h0;
    shamt = 5'd0;
    arith = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out", out, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    op(32'hF000_0000, 5'd4, 1'b0, 1'b0);
    idle(2);
    op(32'h8000_0000, 5'd31, 1'b1, 1'b0);
    idle(1);
    op(32'h1234_5678, 5'd0, 1'b0, 1'b0);
    idle(2);
    // Inputs and start toggle throughout SHIFT/DONE; only the captured operands count.
    op(32'hA5A5_0F0F, 5'd9, 1'b1, 1'b1);
    op(32'h7FFF_FFFF, 5'd13, 1'b1, 1'b1);
    idle(1);

    // Asynchronous reset between edges aborts the operation in flight.
    issue(32'hDEAD_BEEF, 5'd20, 1'b1);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", out, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    sb.delete();
    last_exp = 32'h0;
    start = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    start = 1'b0;
    idle(3);
    op(32'hC000_0001, 5'd5, 1'b1, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      logic [31:0] a;
      a = $urandom;
      op(a, 5'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
